dma_rd_engine: RTL and testbench

DMA_RD_ENGINE -- requirements
Module: dma_rd_engine

---
 rtl/dma_pkg.sv | 14 +
 rtl/dma_sync_fifo.sv | 56 +++++
 rtl/dma_rd_engine.sv | 131 +++++++++++++
 tb/tb_dma_rd_engine.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared types and widths for the DMA read engine.
package dma_pkg;

  localparam int DATA_W = 128;
  localparam int ADDR_W = 32;
  localparam int LEN_W  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } dma_state_e;

endpackage

// File: rtl/dma_sync_fifo.sv
// Single-clock FIFO; read data is zero while empty so outputs idle at 0.
module dma_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   count_q, count_d;
  logic             push_ok, pop_ok;

  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (PTR_W+1)'(1);
      2'b01:   count_d = count_q - (PTR_W+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dma_rd_engine.sv
// Descriptor-driven RAM reader streaming 128-bit beats through a credit-limited FIFO.
// Optional DMA_RD_BYTE_ADDR_EN: byte addressing (16-byte step, low nibble cleared).
module dma_rd_engine
  import dma_pkg::*;
#(
  parameter int OUT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [ADDR_W-1:0] desc_addr,
  input  logic [LEN_W-1:0]  desc_len,
  output logic              RdEn,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] RdData,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = $clog2(OUT_DEPTH) + 1;

`ifdef DMA_RD_BYTE_ADDR_EN
  localparam logic [ADDR_W-1:0] ADDR_STEP = 32'd16;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 32'hFFFF_FFF0;
`else
  localparam logic [ADDR_W-1:0] ADDR_STEP = 32'd1;
  localparam logic [ADDR_W-1:0] ADDR_MASK = 32'hFFFF_FFFF;
`endif

  dma_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  remain_q, remain_d;
  logic              inflight_q, last_inflight_q;
  logic              done_q, done_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty, fifo_pop;
  logic [DATA_W:0]   fifo_rdata;
  logic [CNT_W:0]    occupancy;
  logic              accept, rd_go, final_rd;

  assign desc_ready = (state_q == ST_IDLE) && rst_n;
  assign accept     = desc_valid && desc_ready;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q;

  // Credit counts beats already buffered plus the read whose data lands next cycle.
  assign occupancy  = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q};
  assign rd_go      = (state_q == ST_READ) && (remain_q != '0) && !fifo_full &&
                      (occupancy < (CNT_W+1)'(OUT_DEPTH));
  assign final_rd   = rd_go && (remain_q == LEN_W'(1));

  assign RdEn       = rd_go;
  assign RdAddr     = addr_q;

  assign fifo_pop   = !fifo_empty && out_ready;
  assign out_valid  = !fifo_empty;
  assign out_data   = fifo_rdata[DATA_W-1:0];
  assign out_last   = fifo_rdata[DATA_W];

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    remain_d = remain_q;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d   = desc_addr & ADDR_MASK;
          remain_d = desc_len;
          if (desc_len == '0) done_d  = 1'b1;
          else                state_d = ST_READ;
        end
      end
      ST_READ: begin
        if (rd_go) begin
          addr_d   = addr_q + ADDR_STEP;
          remain_d = remain_q - LEN_W'(1);
          if (final_rd) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_pop && out_last) begin
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      addr_q          <= '0;
      remain_q        <= '0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      remain_q        <= remain_d;
      inflight_q      <= rd_go;
      last_inflight_q <= final_rd;
      done_q          <= done_d;
    end
  end

  // RAM data arrives one cycle after its strobe and is pushed unconditionally.
  dma_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .wdata_i ({last_inflight_q, RdData}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: tb/tb_dma_rd_engine.sv
// Directed and randomized bench for dma_rd_engine against a descriptor-level model.
module tb_dma_rd_engine;

  localparam int DEPTH = 4;
`ifdef DMA_RD_BYTE_ADDR_EN
  localparam logic [31:0] STEP = 32'd16;
  localparam logic [31:0] MASK = 32'hFFFF_FFF0;
`else
  localparam logic [31:0] STEP = 32'd1;
  localparam logic [31:0] MASK = 32'hFFFF_FFFF;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         desc_valid = 1'b0;
  logic         desc_ready;
  logic [31:0]  desc_addr = '0;
  logic [15:0]  desc_len = '0;
  logic         RdEn;
  logic [31:0]  RdAddr;
  logic [127:0] RdData;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [127:0] out_data;
  logic         out_last;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [95:0]  salt = '0;
  logic [31:0]  rd_q[$];
  int           rd_cyc[$];
  logic [128:0] beat_q[$];
  int           beat_cyc[$];
  int           done_cnt = 0;
  int           done_cyc = -1;
  bit           busy_seen = 0;
  bit           stall_prev = 0;
  logic [128:0] prev_beat = '0;
  bit           rnd_ready = 0;

  dma_rd_engine #(.OUT_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .desc_valid (desc_valid),
    .desc_ready (desc_ready),
    .desc_addr  (desc_addr),
    .desc_len   (desc_len),
    .RdEn       (RdEn),
    .RdAddr     (RdAddr),
    .RdData     (RdData),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RAM returns {salt, address} one cycle after the strobe, garbage otherwise.
  always @(posedge clk) begin
    if (RdEn) RdData <= {salt, RdAddr};
    else      RdData <= {$urandom, $urandom, $urandom, $urandom};
  end

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      stall_prev = 0;
    end else begin
      if (RdEn) begin
        rd_q.push_back(RdAddr);
        rd_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) begin
        beat_q.push_back({out_last, out_data});
        beat_cyc.push_back(cyc);
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (busy) busy_seen = 1;
      if (stall_prev) begin
        chk("hold_valid", 160'(out_valid), 160'(1));
        chk("hold_beat", 160'({out_last, out_data}), 160'(prev_beat));
      end
      stall_prev = out_valid && !out_ready;
      prev_beat  = {out_last, out_data};
    end
  end

  task automatic clear_log();
    rd_q.delete();
    rd_cyc.delete();
    beat_q.delete();
    beat_cyc.delete();
    busy_seen = 0;
  endtask

  task automatic send_desc(input logic [31:0] a, input logic [15:0] l, output int acc);
    int n = 0;
    @(posedge clk); #1;
    desc_valid = 1'b1;
    desc_addr  = a;
    desc_len   = l;
    while (!desc_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!desc_ready) chk("accept_timeout", 160'(0), 160'(1));
    @(posedge clk); #1;
    acc = cyc;
    desc_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      @(posedge clk); #1;
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (done_cnt == start) chk("done_timeout", 160'(0), 160'(1));
    out_ready = 1'b1;
  endtask

  // Expected stream: address base+i*STEP (mod 2^32), data {salt, addr}, last on beat len-1.
  task automatic check_desc(input string tag, input logic [31:0] a, input int len,
                            input int acc, input int done_before, input bit strict);
    logic [31:0] base = a & MASK;
    logic [31:0] ea;
    chk({tag, "_nrd"}, 160'(rd_q.size()), 160'(len));
    chk({tag, "_nbeat"}, 160'(beat_q.size()), 160'(len));
    for (int i = 0; i < len; i++) begin
      ea = base + STEP * 32'(i);
      if (i < rd_q.size()) chk({tag, "_addr"}, 160'(rd_q[i]), 160'(ea));
      if (i < beat_q.size())
        chk({tag, "_beat"}, 160'(beat_q[i]), 160'({(i == len - 1), salt, ea}));
      if (strict && i < rd_cyc.size()) chk({tag, "_rdcyc"}, 160'(rd_cyc[i]), 160'(acc + i));
      if (strict && i < beat_cyc.size()) chk({tag, "_beatcyc"}, 160'(beat_cyc[i]), 160'(acc + 2 + i));
    end
    if (rd_cyc.size() > 0) chk({tag, "_first_rd"}, 160'(rd_cyc[0]), 160'(acc));
    chk({tag, "_done_cnt"}, 160'(done_cnt), 160'(done_before + 1));
    if (beat_cyc.size() > 0)
      chk({tag, "_done_cyc"}, 160'(done_cyc), 160'(beat_cyc[beat_cyc.size() - 1] + 1));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, dbefore, len, n;
    logic [31:0] a;

    // reset values
    #1;
    chk("rst_rden", 160'(RdEn), 160'(0));
    chk("rst_rdaddr", 160'(RdAddr), 160'(0));
    chk("rst_valid", 160'(out_valid), 160'(0));
    chk("rst_data", 160'({out_last, out_data}), 160'(0));
    chk("rst_busy", 160'(busy), 160'(0));
    chk("rst_done", 160'(done), 160'(0));
    chk("rst_ready", 160'(desc_ready), 160'(0));
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 chk("post_rst_ready", 160'(desc_ready), 160'(1));

    // scenario 1: addr 0x10 len 4, mem[n]=n
    salt = '0;
    clear_log();
    dbefore = done_cnt;
    send_desc(32'h10, 16'd4, acc);
    chk("s1_busy", 160'(busy), 160'(1));
    chk("s1_not_ready", 160'(desc_ready), 160'(0));
    wait_done(100);
    check_desc("s1", 32'h10, 4, acc, dbefore, 1'b1);
    chk("s1_idle", 160'({busy, desc_ready}), 160'(2'b01));

    // scenario 2: len 8 with 10-cycle stall
    salt = {$urandom, $urandom, $urandom};
    a = $urandom;
    clear_log();
    dbefore = done_cnt;
    out_ready = 1'b0;
    send_desc(a, 16'd8, acc);
    repeat (10 - (cyc - acc)) begin @(posedge clk); #1; end
    chk("s2_rd_before_release", 160'(rd_q.size()), 160'(DEPTH));
    out_ready = 1'b1;
    wait_done(100);
    check_desc("s2", a, 8, acc, dbefore, 1'b0);

    // scenario 3: zero length
    clear_log();
    dbefore = done_cnt;
    send_desc(32'h55, 16'd0, acc);
    repeat (3) begin @(posedge clk); #1; end
    chk("s3_nrd", 160'(rd_q.size()), 160'(0));
    chk("s3_done_cnt", 160'(done_cnt), 160'(dbefore + 1));
    chk("s3_done_cyc", 160'(done_cyc), 160'(acc));
    chk("s3_busy", 160'(busy_seen), 160'(0));

`ifndef DMA_RD_BYTE_ADDR_EN
    // scenario 4: address wrap in word mode
    clear_log();
    dbefore = done_cnt;
    send_desc(32'hFFFF_FFFE, 16'd3, acc);
    wait_done(100);
    check_desc("s4", 32'hFFFF_FFFE, 3, acc, dbefore, 1'b1);
    if (rd_q.size() == 3) chk("s4_wrap", 160'(rd_q[2]), 160'(32'h0));
`else
    // scenario 6: byte addressing ignores low nibble
    clear_log();
    dbefore = done_cnt;
    send_desc(32'h107, 16'd2, acc);
    wait_done(100);
    check_desc("s6", 32'h107, 2, acc, dbefore, 1'b1);
    if (rd_q.size() == 2) chk("s6_addr", 160'({rd_q[0], rd_q[1]}), 160'({32'h100, 32'h110}));
`endif

    // scenario 5: reset after second beat of len 6
    clear_log();
    send_desc(32'h200, 16'd6, acc);
    n = 0;
    while (beat_q.size() < 2 && n < 50) begin @(posedge clk); #1; n++; end
    chk("s5_two_beats", 160'(beat_q.size() >= 2), 160'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("s5_rden", 160'(RdEn), 160'(0));
    chk("s5_rdaddr", 160'(RdAddr), 160'(0));
    chk("s5_out", 160'({out_valid, out_last, out_data}), 160'(0));
    chk("s5_ctl", 160'({busy, done, desc_ready}), 160'(0));
    dbefore = done_cnt;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b1;
    #1;
    chk("s5_ready_after", 160'({desc_ready, busy}), 160'(2'b10));
    repeat (4) begin @(posedge clk); #1; end
    chk("s5_no_done", 160'(done_cnt), 160'(dbefore));
    clear_log();
    salt = {$urandom, $urandom, $urandom};
    send_desc(32'h300, 16'd2, acc);
    wait_done(100);
    check_desc("s5_new", 32'h300, 2, acc, dbefore, 1'b1);

    // randomized descriptors with random backpressure
    for (int k = 0; k < 10; k++) begin
      salt = {$urandom, $urandom, $urandom};
      a = (k % 3 == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      len = $urandom_range(1, 12);
      clear_log();
      dbefore = done_cnt;
      rnd_ready = 1;
      send_desc(a, 16'(len), acc);
      wait_done(400);
      rnd_ready = 0;
      check_desc("rnd", a, len, acc, dbefore, 1'b0);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
